// File: rtl/sr_chain_pkg.sv
// sr_chain_pkg: shared definitions for the configuration-chain controller.
// Holds the register-window offsets, CTRL/status bit positions and the
// sequencing FSM state type used by sr_chain_ctrl.
package sr_chain_pkg;

    // Register offsets within the 256-byte window
    localparam logic [7:0] CTRL_OFF = 8'h00;
    localparam logic [7:0] BUF_OFF  = 8'h10;

    // CTRL write bits
    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_ABORT  = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;
    localparam int unsigned CTRL_CLR    = 4;

    // CTRL read (status) bits; [31:16] carry CHAIN_LEN
    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_DONE    = 1;
    localparam int unsigned STAT_IRQ_EN  = 2;
    localparam int unsigned STAT_ABORTED = 3;
    localparam int unsigned STAT_ERR     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_e;

endpackage

// File: rtl/sr_chain_ctrl.sv
// sr_chain_ctrl: Wishbone-programmable sequencer for the user-area
// configuration shift register. Software fills a word buffer, writes START,
// and the block shifts CHAIN_LEN bits into the chain LSB-first while
// capturing the chain's serial output back into the buffer, then pulses a
// latch strobe and raises done (and irq when enabled).
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   wb_addr/valid/wen/wstrb/wdata  bus request (valid = cyc && stb)
//   rdata, ready        read data and one-cycle acknowledge
//   sc_shift, sc_din    chain shift enable and serial data into the chain
//   sc_dout             chain last-stage output (registered in the chain)
//   sc_latch            one-cycle chain update strobe
//   irq                 level interrupt: done && irq_en
module sr_chain_ctrl
    import sr_chain_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 164,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wb_addr,
    input  logic        valid,
    input  logic        wen,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        sc_shift,
    output logic        sc_din,
    input  logic        sc_dout,
    output logic        sc_latch,
    output logic        irq
);

    localparam int unsigned NW    = (CHAIN_LEN + 31) / 32;
    localparam int unsigned BUF_W = NW * 32;
    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
    // Bits of the buffer that belong to the chain; the rest are never shifted
    localparam logic [BUF_W-1:0] CHAIN_MASK = {BUF_W{1'b1}} >> (BUF_W - CHAIN_LEN);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             err_q, err_d;
    logic             irq_en_q, irq_en_d;
    logic             ready_q, ready_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             sc_shift_q, sc_shift_d;
    logic             sc_din_q, sc_din_d;
    logic             sc_latch_q, sc_latch_d;

    // Address decode
    logic             hit;
    logic [7:0]       off;
    logic             ctrl_sel;
    logic [5:0]       word_sel;
    logic             buf_sel;
    logic             wr_fire;
    logic             ctrl_wr;
    logic             busy;
    logic [31:0]      ctrl_rd;
    logic [31:0]      lane_mask;
    logic [BUF_W-1:0] rd_sh;
    logic [BUF_W-1:0] wr_vec;
    logic [BUF_W-1:0] wr_msk;
    logic [BUF_W-1:0] shifted;

    assign hit       = (wb_addr[31:8] == BASE_ADDR[31:8]);
    assign off       = wb_addr[7:0];
    assign ctrl_sel  = (off == CTRL_OFF);
    assign word_sel  = off[7:2] - BUF_OFF[7:2];
    assign buf_sel   = (off[1:0] == 2'b00) && (off >= BUF_OFF) && ({26'b0, word_sel} < NW);
    // A write commits on the edge that ends its ready cycle
    assign wr_fire   = ready_q && valid && wen && hit;
    assign ctrl_wr   = wr_fire && ctrl_sel && wstrb[0];
    assign busy      = (state_q != IDLE);
    assign ctrl_rd   = {16'(CHAIN_LEN), 11'b0, err_q, aborted_q, irq_en_q, done_q, busy};
    assign lane_mask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    assign rd_sh     = buf_q >> {word_sel, 5'b0};
    assign wr_vec    = BUF_W'(wdata) << {word_sel, 5'b0};
    assign wr_msk    = BUF_W'(lane_mask) << {word_sel, 5'b0};
    // Chain bits move one place toward bit 0; sc_dout enters at CHAIN_LEN-1
    assign shifted   = (buf_q & ~CHAIN_MASK)
                     | ((buf_q >> 1) & (CHAIN_MASK >> 1))
                     | (BUF_W'(sc_dout) << (CHAIN_LEN - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        done_d    = done_q;
        aborted_d = aborted_q;
        err_d     = err_q;
        irq_en_d  = irq_en_q;
        ready_d   = valid && hit && !ready_q;
        rdata_d   = '0;

        if (ready_d && !wen) begin
            if (ctrl_sel) begin
                rdata_d = ctrl_rd;
            end else if (buf_sel) begin
                rdata_d = rd_sh[31:0];
            end
        end

        if (ctrl_wr) begin
            irq_en_d = wdata[CTRL_IRQ_EN];
            if (wdata[CTRL_CLR]) begin
                done_d    = 1'b0;
                aborted_d = 1'b0;
                err_d     = 1'b0;
            end
            if (busy && wdata[CTRL_START]) begin
                err_d = 1'b1;
            end
        end

        if (wr_fire && buf_sel) begin
            if (busy) begin
                err_d = 1'b1;
            end else begin
                buf_d = (buf_q & ~wr_msk) | (wr_vec & wr_msk);
            end
        end

        unique case (state_q)
            IDLE: begin
                if (ctrl_wr && wdata[CTRL_START]) begin
                    state_d   = SHIFT;
                    cnt_d     = CNT_W'(CHAIN_LEN);
                    done_d    = 1'b0;
                    aborted_d = 1'b0;
                end
            end
            SHIFT: begin
                // The chain shifts on this edge regardless of abort, so the
                // buffer follows it to stay aligned with the chain contents
                buf_d = shifted;
                cnt_d = cnt_q - CNT_W'(1);
                if (ctrl_wr && wdata[CTRL_ABORT]) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                state_d = IDLE;
                if (ctrl_wr && wdata[CTRL_ABORT]) begin
                    aborted_d = 1'b1;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Chain outputs are registered from the next state
        sc_shift_d = (state_d == SHIFT);
        sc_latch_d = (state_d == LATCH);
        sc_din_d   = (state_d == SHIFT) && buf_d[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            buf_q      <= '0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            err_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            sc_shift_q <= 1'b0;
            sc_din_q   <= 1'b0;
            sc_latch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            err_q      <= err_d;
            irq_en_q   <= irq_en_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            sc_shift_q <= sc_shift_d;
            sc_din_q   <= sc_din_d;
            sc_latch_q <= sc_latch_d;
        end
    end

    assign ready    = ready_q;
    assign rdata    = rdata_q;
    assign sc_shift = sc_shift_q;
    assign sc_din   = sc_din_q;
    assign sc_latch = sc_latch_q;
    assign irq      = done_q && irq_en_q;

endmodule

// File: tb/tb_sr_chain_ctrl.sv
// Directed bench for sr_chain_ctrl with a 164-stage chain model attached.
module tb_sr_chain_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          CL   = 164;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wb_addr;
    logic        valid;
    logic        wen;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        sc_shift;
    logic        sc_din;
    logic        sc_dout;
    logic        sc_latch;
    logic        irq;

    sr_chain_ctrl #(.CHAIN_LEN(CL), .BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .reset    (reset),
        .wb_addr  (wb_addr),
        .valid    (valid),
        .wen      (wen),
        .wstrb    (wstrb),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .sc_shift (sc_shift),
        .sc_din   (sc_din),
        .sc_dout  (sc_dout),
        .sc_latch (sc_latch),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // Chain model: Sin enters stage 0, Sout is stage CL-1
    logic [CL-1:0] chain = '0;
    always @(posedge clk) if (sc_shift) chain <= {chain[CL-2:0], sc_din};
    assign sc_dout = chain[CL-1];

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    // Activity recorder, sampled on the falling edge
    int           n_shift, n_latch, first_shift, last_shift, latch_cyc, irq_rise;
    logic         irq_prev = 1'b0;
    logic [191:0] din_bits;
    always @(negedge clk) begin
        if (sc_shift) begin
            if (n_shift == 0) first_shift = edge_cnt;
            last_shift = edge_cnt;
            if (n_shift < 192) din_bits[8'(n_shift)] = sc_din;
            n_shift++;
        end
        if (sc_latch) begin
            n_latch++;
            latch_cyc = edge_cnt;
        end
        if (irq && !irq_prev) irq_rise = edge_cnt;
        irq_prev = irq;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic mon_clear();
        n_shift = 0; n_latch = 0;
        first_shift = -1; last_shift = -1; latch_cyc = -1; irq_rise = -1;
        din_bits = '0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output int t, output bit ok);
        @(negedge clk);
        wb_addr = a; wdata = d; wstrb = s; wen = 1'b1; valid = 1'b1; ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin ok = 1'b1; break; end
        end
        @(posedge clk);
        #1;
        t = edge_cnt;
        valid = 1'b0; wen = 1'b0; wstrb = 4'h0;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d, output bit ok);
        @(negedge clk);
        wb_addr = a; wen = 1'b0; wstrb = 4'h0; valid = 1'b1; ok = 1'b0; d = 'x;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin ok = 1'b1; d = rdata; break; end
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    initial begin
        logic [191:0] orig, exp1, exp4, mask;
        logic [CL-1:0] p2;
        logic [31:0]  rd;
        bit           ok, ack_all;
        int           t, t2, nrdy;

        orig = {32'hF00D_0ACE, 32'h1357_9BDF, 32'hCAFE_BABE, 32'h5A5A_0F0F,
                32'hA5A5_A5A5, 32'h0000_0001};
        mask = {28'b0, {CL{1'b1}}};
        exp1 = orig;
        for (int j = 0; j < CL; j++) exp1[j] = 1'b1;
        p2 = {4'h9, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 32'h0F1E_2D3C};
        exp4 = {28'hF00D_0AC, 164'b0};
        for (int j = 0; j < CL; j++) exp4[j] = p2[CL-1-j];

        reset = 1'b1; valid = 1'b0; wen = 1'b0; wstrb = 4'h0; wdata = '0; wb_addr = '0;
        mon_clear();
        repeat (3) @(negedge clk);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_outs", 32'({ready, sc_shift, sc_din, sc_latch, irq}), 32'h0);
        reset = 1'b0;
        wb_read(BASE, rd, ok);
        chk("rst_ctrl", rd, 32'h00A4_0000);
        wb_read(BASE + 32'h10, rd, ok);
        chk("rst_buf0", rd, 32'h0);

        // Load buffer
        ack_all = 1'b1;
        for (int w = 0; w < 6; w++) begin
            wb_write(BASE + 32'h10 + 32'(4 * w), 32'(orig >> (32 * w)), 4'hF, t, ok);
            ack_all &= ok;
        end
        chk("load_ack", 32'(ack_all), 32'h1);
        wb_read(BASE + 32'h1C, rd, ok);
        chk("load_rb3", rd, 32'hCAFE_BABE);

        // Run 1: chain preloaded all ones, irq disabled
        chain <= '1;
        mon_clear();
        wb_write(BASE, 32'h1, 4'h1, t, ok);
        repeat (170) @(negedge clk);
        chk("r1_nshift", n_shift, CL);
        chk("r1_first", first_shift, t);
        chk("r1_last", last_shift, t + CL - 1);
        chk("r1_nlatch", n_latch, 1);
        chk("r1_latch_cyc", latch_cyc, t + CL);
        chk("r1_no_irq", irq_rise, -1);
        for (int w = 0; w < 6; w++)
            chk($sformatf("r1_din_w%0d", w), 32'(din_bits >> (32 * w)), 32'((orig & mask) >> (32 * w)));
        wb_read(BASE, rd, ok);
        chk("r1_ctrl", rd, 32'h00A4_0002);
        for (int w = 0; w < 6; w++) begin
            wb_read(BASE + 32'h10 + 32'(4 * w), rd, ok);
            chk($sformatf("r1_buf%0d", w), rd, 32'(exp1 >> (32 * w)));
        end

        // Run 2: chain now holds the original buffer; irq enabled
        mon_clear();
        wb_write(BASE, 32'h5, 4'h1, t, ok);
        repeat (170) @(negedge clk);
        chk("r2_nshift", n_shift, CL);
        chk("r2_latch_cyc", latch_cyc, t + CL);
        chk("r2_irq_rise", irq_rise, t + CL + 1);
        for (int w = 0; w < 6; w++)
            chk($sformatf("r2_din_w%0d", w), 32'(din_bits >> (32 * w)), 32'((exp1 & mask) >> (32 * w)));
        wb_read(BASE, rd, ok);
        chk("r2_ctrl", rd, 32'h00A4_0006);
        for (int w = 0; w < 6; w++) begin
            wb_read(BASE + 32'h10 + 32'(4 * w), rd, ok);
            chk($sformatf("r2_buf%0d", w), rd, 32'(orig >> (32 * w)));
        end
        wb_write(BASE, 32'h14, 4'h1, t, ok);
        @(negedge clk);
        chk("w1c_irq", 32'(irq), 32'h0);
        wb_read(BASE, rd, ok);
        chk("w1c_ctrl", rd, 32'h00A4_0004);

        // Run 3: abort around shift cycle 50
        mon_clear();
        wb_write(BASE, 32'h1, 4'h1, t, ok);
        repeat (47) @(negedge clk);
        wb_write(BASE, 32'h2, 4'h1, t2, ok);
        chk("ab_shift_low", 32'(sc_shift), 32'h0);
        repeat (200) @(negedge clk);
        chk("ab_nshift", n_shift, t2 - t);
        chk("ab_nlatch", n_latch, 0);
        wb_read(BASE, rd, ok);
        chk("ab_ctrl", rd, 32'h00A4_0008);

        // Run 4: buffer write and START while busy
        wb_write(BASE, 32'h10, 4'h1, t, ok);
        chain <= p2;
        mon_clear();
        wb_write(BASE, 32'h1, 4'h1, t, ok);
        repeat (20) @(negedge clk);
        wb_write(BASE + 32'h14, 32'hDEAD_BEEF, 4'hF, t2, ok);
        chk("busy_wr_ack", 32'(ok), 32'h1);
        wb_write(BASE, 32'h1, 4'h1, t2, ok);
        repeat (170) @(negedge clk);
        chk("r4_nshift", n_shift, CL);
        chk("r4_nlatch", n_latch, 1);
        chk("r4_latch_cyc", latch_cyc, t + CL);
        wb_read(BASE, rd, ok);
        chk("r4_ctrl", rd, 32'h00A4_0012);
        wb_read(BASE + 32'h14, rd, ok);
        chk("r4_buf1", rd, 32'(exp4 >> 32));
        wb_read(BASE + 32'h24, rd, ok);
        chk("r4_buf5", rd, 32'(exp4 >> 160));

        // Byte lanes, unmapped offset, window miss
        wb_write(BASE + 32'h18, 32'h1122_3344, 4'hF, t, ok);
        wb_write(BASE + 32'h18, 32'h00CC_0000, 4'b0100, t, ok);
        wb_read(BASE + 32'h18, rd, ok);
        chk("byte_wr", rd, 32'h11CC_3344);
        wb_read(BASE + 32'h40, rd, ok);
        chk("unmapped_ack", 32'(ok), 32'h1);
        chk("unmapped_rd", rd, 32'h0);
        @(negedge clk);
        wb_addr = BASE + 32'h100; wen = 1'b0; valid = 1'b1; nrdy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready !== 1'b0) nrdy++;
        end
        valid = 1'b0;
        chk("miss_noack", nrdy, 0);

        // Reset in the middle of a shift
        wb_write(BASE, 32'h14, 4'h1, t, ok);
        chain <= p2;
        mon_clear();
        wb_write(BASE, 32'h1, 4'h1, t, ok);
        repeat (79) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_outs", 32'({ready, sc_shift, sc_din, sc_latch, irq}), 32'h0);
        chk("mrst_rdata", rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        chk("mrst_nlatch", n_latch, 0);
        wb_read(BASE, rd, ok);
        chk("mrst_ctrl", rd, 32'h00A4_0000);
        wb_read(BASE + 32'h10, rd, ok);
        chk("mrst_buf0", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sr_chain_ctrl.md
# sr_chain_ctrl

Wishbone-programmable controller that sequences the user-area configuration shift register (the 164-bit `SR` chain). Software loads a word buffer, writes START, and the block shifts `CHAIN_LEN` bits into the chain LSB-first while capturing the chain's serial output. It then pulses a latch strobe and raises done/irq. It sits between the wrapper's Wishbone decode (`valid`/`wen`) and the chain's `Sin`/`Sout`, and replaces direct LA bit-banging of the chain.

## Interface
- `CHAIN_LEN`, default 164: chain length in bits; 1..1024.
- `BASE_ADDR`, default 32'h3000_0000: register window base; window is 256 bytes.
- `NW` (localparam) = ceil(CHAIN_LEN/32): buffer words; 6 at default.
- `clk` in 1: single clock, `wb_clk_i` domain.
- `reset` in 1: synchronous, active-high.
- `wb_addr` in 32: byte address.
- `valid` in 1: cyc&&stb.
- `wen` in 1: write enable.
- `wstrb` in 4: byte lanes (sel & we).
- `wdata` in 32: write data.
- `rdata` out 32: read data; 0 when `ready` low.
- `ready` out 1: one-cycle ack.
- `sc_shift` out 1: chain shift enable.
- `sc_din` out 1: serial data to chain (`Sin`).
- `sc_dout` in 1: chain last-stage output (`Sout`), registered in chain.
- `sc_latch` out 1: one-cycle update strobe.
- `irq` out 1: level; done && IRQ_EN.

## Operation
- Window hit: `wb_addr[31:8] == BASE_ADDR[31:8]`. Misses are never acked.
- Offset 0x00 CTRL write (lane 0 only):
  - bit0 START
  - bit1 ABORT
  - bit2 IRQ_EN (stored)
  - bit4 write-1 clears done, aborted, err.
- Offset 0x00 CTRL read:
  - bit0 busy
  - bit1 done
  - bit2 irq_en
  - bit3 aborted
  - bit4 err
  - [31:16] CHAIN_LEN
- Offsets 0x10+4*i, i<NW: buffer word i. Byte lanes are honored per `wstrb`. Buffer bit k = word k/32, bit k%32.
- Other in-window offsets: read 0, writes ignored, still acked.
- FSM IDLE → SHIFT → LATCH → IDLE.
  - IDLE + START: load bit counter with CHAIN_LEN, clear done/aborted, enter SHIFT.
  - SHIFT: `sc_shift`=1, `sc_din`=buf[0]. At each edge, buf[CHAIN_LEN-1:0] ← {sc_dout, buf[CHAIN_LEN-1:1]} and the counter decrements. When the counter reaches 1, go to LATCH.
  - LATCH: `sc_latch`=1 for one cycle. At its end, done←1 and return to IDLE.
- After a run, buf[CHAIN_LEN-1:0] holds the previous chain contents in chain order. Bits ≥CHAIN_LEN are untouched.
- Busy = state≠IDLE.
- START while busy: ignored, err←1.
- Buffer write while busy: ignored, err←1; ack still given. Buffer reads while busy return the in-flight value.
- ABORT while busy: next state IDLE, no latch, aborted←1, done stays 0.
- ABORT while idle: no effect. START and ABORT in the same write while idle: START wins.
- ABORT arriving in the final SHIFT cycle: abort wins, no latch.

## Timing
- `ready` is high exactly one cycle, the cycle after `valid` is first sampled with `ready` low. No back-to-back acks without `valid` dropping or one idle cycle.
- A write commits at the edge ending the `ready` cycle. Read data is presented during `ready`.
- START committed at edge T:
  - `sc_shift` high cycles T+1..T+CHAIN_LEN.
  - `sc_latch` high in cycle T+CHAIN_LEN+1.
  - done/irq visible from T+CHAIN_LEN+2.
- `sc_dout` is sampled at the same edge that shifts the chain.
- Reset values: `ready`=0, `rdata`=0, `sc_shift`=0, `sc_din`=0, `sc_latch`=0, `irq`=0. State IDLE, counter 0, all flags 0, buffer 0.
- Reset mid-SHIFT: outputs are low from the next cycle; no latch pulse.

## Structure
- Package `sr_chain_pkg`:
  - register offsets (CTRL 0x00, BUF 0x10)
  - CTRL bit indices
  - state enum {IDLE, SHIFT, LATCH}
- Single module. Register decode and FSM are inline; the buffer is a flat NW*32 vector. No sub-module is needed.

## Test plan
- Load words 0x0000_0001, 0xA5A5_A5A5, … (6 words), START; chain model preloaded 0xFF pattern → 164 `sc_shift` cycles; `sc_din` stream equals buffer LSB-first; one `sc_latch` at T+165; buffer reads back the 0xFF pattern; done=1.
- Same run with IRQ_EN=1 → `irq` rises at T+166; W1C bit4 → `irq` and done drop.
- ABORT written during shift cycle 50 → `sc_shift` low after commit, no `sc_latch`, aborted=1, done=0.
- Buffer write 0xDEAD_BEEF while busy → ack, err=1, word unchanged. START while busy → err=1, run length still 164.
- Byte write `wstrb`=0100 data 0x00CC_0000 to word 2 holding 0x1122_3344 → readback 0x11CC_3344. Access at BASE+0x100 → no `ready` for 20 cycles.
- Assert `reset` at shift cycle 80 → all outputs 0 next cycle, CTRL reads 0x00A4_0000.
